// File: rtl/wb_host_master.sv
// Wishbone B3 classic initiator: command stream in, one response per bus beat out.
// Optional per-beat ack timeout enabled by defining WB_HOST_TIMEOUT_EN.
module wb_host_master #(
    parameter int LEN_W          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_adr,
    input  logic [31:0]      cmd_dat,
    input  logic [3:0]       cmd_sel,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_dat,
    output logic             rsp_err,
    output logic             rsp_last,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic             busy
);

    if (LEN_W < 1) begin : g_bad_len
        $error("LEN_W must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } state_t;

    state_t             state_q, state_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic [LEN_W-1:0]   beats_q, beats_d;
    logic               rv_q, rv_d;
    logic [31:0]        rdat_q, rdat_d;
    logic               rerr_q, rerr_d;
    logic               rlast_q, rlast_d;

`ifdef WB_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]      tmo_q, tmo_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            beats_q <= '0;
            rv_q    <= 1'b0;
            rdat_q  <= '0;
            rerr_q  <= 1'b0;
            rlast_q <= 1'b0;
`ifdef WB_HOST_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            beats_q <= beats_d;
            rv_q    <= rv_d;
            rdat_q  <= rdat_d;
            rerr_q  <= rerr_d;
            rlast_q <= rlast_d;
`ifdef WB_HOST_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        beats_d = beats_q;
        rv_d    = rv_q;
        rdat_d  = rdat_q;
        rerr_d  = rerr_q;
        rlast_d = rlast_q;
`ifdef WB_HOST_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    beats_d = cmd_len;
                    cyc_d   = 1'b1;
                    state_d = REQ;
`ifdef WB_HOST_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            REQ: begin
                if (wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    rdat_d  = we_q ? 32'h0 : wbm_dat_i;
                    rerr_d  = 1'b0;
                    rlast_d = (beats_q == '0);
                    rv_d    = 1'b1;
                    state_d = RSP;
                end
`ifdef WB_HOST_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    // abandon the rest of the burst on a dead slave
                    cyc_d   = 1'b0;
                    rdat_d  = 32'h0;
                    rerr_d  = 1'b1;
                    rlast_d = 1'b1;
                    rv_d    = 1'b1;
                    state_d = RSP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            RSP: begin
                if (rv_q && rsp_ready) begin
                    rv_d = 1'b0;
                    if (rlast_q || rerr_q) begin
                        state_d = IDLE;
                    end else begin
                        adr_d   = adr_q + 32'd4;
                        beats_d = beats_q - 1'b1;
                        cyc_d   = 1'b1;
                        state_d = REQ;
`ifdef WB_HOST_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                rv_d    = 1'b0;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rsp_valid = rv_q;
    assign rsp_dat   = rdat_q;
    assign rsp_err   = rerr_q;
    assign rsp_last  = rlast_q;

endmodule
